// File: rtl/nbit_sum_accumulator.sv
// nbit_sum_accumulator
//   Sums COUNT consecutive N-bit samples from the adder into a widened
//   accumulator and presents each block total on a valid/ready output.
//   The accumulator is wide enough that COUNT*(2^N-1) always fits.
// Ports
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : in_data carries a sample this cycle
//   in_ready   : block can take a sample (high while accumulating)
//   in_data    : unsigned N-bit sample
//   clr        : drop a partially accumulated block (ignored while holding)
//   out_valid  : out_sum holds a completed block total
//   out_ready  : downstream takes out_sum this cycle
//   out_sum    : ACC_W-bit block total
//   out_last   : high in the cycle the total is handed off
module nbit_sum_accumulator #(
  parameter int N     = 2,
  parameter int COUNT = 4,
  parameter int ACC_W = N + $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_last
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               accept;
  logic [ACC_W-1:0]   data_ext;

  // in_ready depends on state only, so there is no combinational path
  // from out_ready or in_valid back to the upstream stage.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_last  = out_valid & out_ready;
  assign out_sum   = out_sum_q;
  assign accept    = in_valid & in_ready;
  assign data_ext  = ACC_W'(in_data);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_sum_d = out_sum_q;
    case (state_q)
      ACCUM: begin
        if (clr) begin
          // abort wins over a sample offered in the same cycle
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == CNT_LAST) begin
            out_sum_d = acc_q + data_ext;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = HOLD;
          end else begin
            acc_d = acc_q + data_ext;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // no bypass: the next block starts one cycle after the handoff
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_sum_q <= out_sum_d;
    end
  end

endmodule

// File: tb/tb_nbit_sum_accumulator.sv
module tb_nbit_sum_accumulator;
  localparam int N = 2, COUNT = 4, ACC_W = 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, clr, out_ready;
  logic [N-1:0]     in_data;
  logic             in_ready, out_valid, out_last;
  logic [ACC_W-1:0] out_sum;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  nbit_sum_accumulator #(.N(N), .COUNT(COUNT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last)
  );

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [N-1:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 2'd3; clr = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_sum !== 4'd0) begin fails++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
    checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b want 0", out_last); end
  endtask

  task automatic test_max_block();
    out_ready = 1'b1;
    send(2'd3); send(2'd3); send(2'd3);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL max_early_valid got %b want 0", out_valid); end
    send(2'd3); #1;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL max_out_valid got %b want 1", out_valid); end
    checks++; if (out_sum !== 4'd12) begin fails++; $display("FAIL max_out_sum got %0d want 12", out_sum); end
    checks++; if (out_last !== 1'b1) begin fails++; $display("FAIL max_out_last got %b want 1", out_last); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL max_in_ready got %b want 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL max_release got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(2'd1); send(2'd2); send(2'd0); send(2'd3);
    // offer samples during HOLD; they must not be taken
    in_valid = 1'b1; in_data = 2'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 4'd6 || out_last !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d] got ready=%b valid=%b sum=%0d last=%b want 0/1/6/0", i, in_ready, out_valid, out_sum, out_last);
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    checks++; if (out_last !== 1'b1) begin fails++; $display("FAIL bp_last got %b want 1", out_last); end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %b want 0", out_valid); end
    send(2'd1); send(2'd1); send(2'd1); send(2'd1);
    checks++; if (out_sum !== 4'd4 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_next_block got sum=%0d valid=%b want 4/1", out_sum, out_valid); end
    step();
  endtask

  task automatic test_gaps();
    logic [6:0] vpat;
    logic [1:0] dpat [7];
    vpat = 7'b1010101;
    dpat = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[6-i]; in_data = dpat[i];
      step();
    end
    in_valid = 1'b0; #1;
    checks++; if (out_sum !== 4'd6 || out_valid !== 1'b1) begin fails++; $display("FAIL gaps_sum got sum=%0d valid=%b want 6/1", out_sum, out_valid); end
    step();
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    send(2'd3); send(2'd3);
    clr = 1'b1; in_valid = 1'b1; in_data = 2'd3;
    step();
    clr = 1'b0; in_valid = 1'b0;
    send(2'd1); send(2'd1); send(2'd1);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_early_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
    send(2'd1);
    checks++; if (out_sum !== 4'd4 || out_valid !== 1'b1) begin fails++; $display("FAIL clr_sum got sum=%0d valid=%b want 4/1", out_sum, out_valid); end
    // clr while holding must not disturb the completed total
    clr = 1'b1; step(); clr = 1'b0; #1;
    checks++; if (out_sum !== 4'd4 || out_valid !== 1'b1) begin fails++; $display("FAIL clr_in_hold got sum=%0d valid=%b want 4/1", out_sum, out_valid); end
    out_ready = 1'b1; step();
  endtask

  task automatic test_reset_midblock();
    out_ready = 1'b1;
    send(2'd3); send(2'd3);
    rst = 1'b1; step(); rst = 1'b0;
    send(2'd2); send(2'd0); send(2'd1); send(2'd2);
    checks++; if (out_sum !== 4'd5 || out_valid !== 1'b1) begin fails++; $display("FAIL rst_mid got sum=%0d valid=%b want 5/1", out_sum, out_valid); end
    step();
  endtask

  task automatic test_random();
    bit m_hold = 1'b0;
    int m_acc = 0, m_cnt = 0, m_sum = 0, blocks = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 1);
      in_data   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (in_ready !== !m_hold || out_valid !== m_hold) begin
        fails++; $display("FAIL rand_hs[%0d] got ready=%b valid=%b want %b/%b", i, in_ready, out_valid, !m_hold, m_hold);
      end
      if (m_hold && out_ready) begin
        checks++; if (out_sum !== 4'(m_sum) || out_last !== 1'b1) begin
          fails++; $display("FAIL rand_sum[%0d] got sum=%0d last=%b want %0d/1", blocks, out_sum, out_last, m_sum);
        end
        blocks++;
        m_hold = 1'b0;
      end else if (!m_hold && in_valid) begin
        m_acc += in_data; m_cnt++;
        if (m_cnt == COUNT) begin m_sum = m_acc; m_acc = 0; m_cnt = 0; m_hold = 1'b1; end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_max_block();
    test_backpressure();
    test_gaps();
    test_clr();
    test_reset_midblock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
